// File: rtl/mem_pkg.sv
// Shared operation/state types and op-class helpers for mem_access_unit.
// MEM_ALIGN_CHECK_EN (see mem_access_unit) is the only consumer of needs_align.
package mem_pkg;

    typedef enum logic [3:0] {
        LB  = 4'h0,
        LBU = 4'h1,
        LH  = 4'h2,
        LHU = 4'h3,
        LW  = 4'h4,
        LWL = 4'h5,
        LWR = 4'h6,
        SB  = 4'h8,
        SH  = 4'h9,
        SW  = 4'hA,
        SWL = 4'hB,
        SWR = 4'hC
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Wide enough for READ_LAT-1 with READ_LAT up to 8.
    localparam int CNT_W = 3;

    function automatic logic is_load(input mem_op_t op);
        return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {SB, SH, SW, SWL, SWR};
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] needs_align(input mem_op_t op);
        case (op)
            LH, LHU, SH: return 2'b01;
            LW, SW:      return 2'b11;
            default:     return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/data and load merge/extend.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  ea,
    input  logic [31:0] rt,
    input  logic [31:0] m,
    output logic [3:0]  wen,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [4:0]  sh_up;
    logic [4:0]  sh_dn;

    assign ld_byte = m[{ea, 3'b000} +: 8];
    assign ld_half = ea[1] ? m[31:16] : m[15:0];
    assign sh_up   = {ea, 3'b000};
    assign sh_dn   = {~ea, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        wen   = 4'b0000;
        wdata = rt;
        rdata = rt;
        case (op)
            LB:  rdata = {{24{ld_byte[7]}}, ld_byte};
            LBU: rdata = {24'h000000, ld_byte};
            LH:  rdata = {{16{ld_half[15]}}, ld_half};
            LHU: rdata = {16'h0000, ld_half};
            LW:  rdata = m;
            LWL: begin
                case (ea)
                    2'd0: rdata = {m[7:0],  rt[23:0]};
                    2'd1: rdata = {m[15:0], rt[15:0]};
                    2'd2: rdata = {m[23:0], rt[7:0]};
                    2'd3: rdata = m;
                endcase
            end
            LWR: begin
                case (ea)
                    2'd0: rdata = m;
                    2'd1: rdata = {rt[31:24], m[31:8]};
                    2'd2: rdata = {rt[31:16], m[31:16]};
                    2'd3: rdata = {rt[31:8],  m[31:24]};
                endcase
            end
            SB: begin
                wen   = 4'b0001 << ea;
                wdata = {4{rt[7:0]}};
            end
            SH: begin
                wen   = ea[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rt[15:0]}};
            end
            SW: begin
                wen   = 4'b1111;
                wdata = rt;
            end
            SWL: begin
                wen   = 4'b1111 >> ~ea;
                wdata = rt >> sh_dn;
            end
            SWR: begin
                wen   = 4'b1111 << ea;
                wdata = rt << sh_up;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked multi-cycle load/store sequencer between the core and the data SRAM.
// Define MEM_ALIGN_CHECK_EN to trap misaligned LH/LHU/SH/LW/SW with resp_adel/resp_ades.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_rt,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_adel,
    output logic              resp_ades,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    state_t            state, state_nxt;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       rt_q;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept, capture_rt, capture_load;
    logic              misaligned, access;
    logic [3:0]        lane_wen;
    logic [31:0]       lane_wdata, lane_rdata;

    mem_lane_align u_lane_align (
        .op    (op_q),
        .ea    (addr_q[1:0]),
        .rt    (rt_q),
        .m     (sram_rdata),
        .wen   (lane_wen),
        .wdata (lane_wdata),
        .rdata (lane_rdata)
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |(addr_q[1:0] & needs_align(op_q));
    assign resp_adel  = resp_valid && misaligned && is_load(op_q);
    assign resp_ades  = resp_valid && misaligned && is_store(op_q);
`else
    assign misaligned = 1'b0;
    assign resp_adel  = 1'b0;
    assign resp_ades  = 1'b0;
`endif

    // Undefined ops and trapped accesses never touch the SRAM.
    assign access     = (is_load(op_q) || is_store(op_q)) && !misaligned;
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_DONE);
    assign sram_en    = (state == ST_ISSUE) && access;
    assign sram_wen   = sram_en ? lane_wen : 4'b0000;
    assign sram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign sram_wdata = lane_wdata;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        accept       = 1'b0;
        capture_rt   = 1'b0;
        capture_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (is_load(op_q) && !misaligned) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = CNT_W'(READ_LAT - 1);
                end else begin
                    state_nxt  = ST_DONE;
                    capture_rt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt    = ST_DONE;
                    capture_load = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= LB;
            addr_q     <= '0;
            rt_q       <= '0;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                op_q   <= mem_op_t'(req_op);
                addr_q <= req_addr;
                rt_q   <= req_rt;
            end
            if (capture_rt) begin
                resp_rdata <= rt_q;
            end else if (capture_load) begin
                resp_rdata <= lane_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops against a byte-level model.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int AW      = 32;
    localparam int RL      = 3;
    localparam int TIMEOUT = 20;

    typedef struct {
        int          en_count;
        logic [3:0]  wen;
        logic [31:0] wdata;
        int          resp_cycle;
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_rt;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_adel;
    logic          resp_ades;
    logic          sram_en;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    int          obs_en_count, obs_en_cycle, obs_resp_cycle;
    logic [3:0]  obs_wen;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic        obs_adel, obs_ades;
    bit          obs_ready_offer, obs_ready_busy, obs_stray_wen;

    mem_op_t all_ops[12] = '{LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR};

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .READ_LAT(RL)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_rt     (req_rt),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_adel  (resp_adel),
        .resp_ades  (resp_ades),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Reference model: little-endian byte arithmetic on whole words.
    function automatic exp_t model(input mem_op_t op, input logic [31:0] addr,
                                   input logic [31:0] rt, input logic [31:0] m);
        exp_t        e;
        int          ea;
        bit          ld, st, mis;
        logic [31:0] b, h;
        ea  = int'(addr[1:0]);
        ld  = op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
        st  = op inside {SB, SH, SW, SWL, SWR};
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ((op inside {LH, LHU, SH}) && addr[0]) || ((op inside {LW, SW}) && ea != 0);
`endif
        e.en_count   = 0;
        e.wen        = 4'b0000;
        e.wdata      = 32'h0;
        e.resp_cycle = 2;
        e.rdata      = rt;
        e.adel       = mis && ld;
        e.ades       = mis && st;
        if (ld && !mis) begin
            e.en_count   = 1;
            e.resp_cycle = 2 + RL;
            b = (m >> (8 * ea)) & 32'hFF;
            h = (m >> (16 * (ea / 2))) & 32'hFFFF;
            case (op)
                LB:  e.rdata = (b >= 32'd128) ? b - 32'd256 : b;
                LBU: e.rdata = b;
                LH:  e.rdata = (h >= 32'd32768) ? h - 32'd65536 : h;
                LHU: e.rdata = h;
                LW:  e.rdata = m;
                LWL: e.rdata = (m << (8 * (3 - ea))) | (rt & ((32'h1 << (8 * (3 - ea))) - 32'h1));
                default: e.rdata = (m >> (8 * ea)) | (rt & ~(32'hFFFFFFFF >> (8 * ea)));
            endcase
        end else if (st && !mis) begin
            e.en_count = 1;
            case (op)
                SB:  begin e.wen = 4'(1 << ea);             e.wdata = (rt & 32'hFF) * 32'h01010101;   end
                SH:  begin e.wen = (ea >= 2) ? 4'hC : 4'h3; e.wdata = (rt & 32'hFFFF) * 32'h00010001; end
                SW:  begin e.wen = 4'hF;                    e.wdata = rt;                            end
                SWL: begin e.wen = 4'((1 << (ea + 1)) - 1); e.wdata = rt >> (8 * (3 - ea));           end
                default: begin e.wen = 4'((15 << ea) & 15); e.wdata = rt << (8 * ea);               end
            endcase
        end
        return e;
    endfunction

    // Offers one op, then observes cycles 1.. after the accept edge until resp_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] m, input bit hold_valid);
        @(negedge clk);
        obs_ready_offer = req_ready;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_rt    = rt;
        @(posedge clk);
        #1;
        req_valid = hold_valid;
        req_op    = 4'($urandom);
        req_addr  = $urandom;
        req_rt    = $urandom;
        obs_en_count = 0; obs_en_cycle = -1; obs_resp_cycle = -1;
        obs_ready_busy = 1'b0; obs_stray_wen = 1'b0;
        obs_wen = '0; obs_addr = '0; obs_wdata = '0; obs_rdata = '0; obs_adel = 1'b0; obs_ades = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (sram_en) begin
                obs_en_count++;
                obs_en_cycle = k;
                obs_wen   = sram_wen;
                obs_addr  = sram_addr;
                obs_wdata = sram_wdata;
            end else if (sram_wen != 4'b0000) begin
                obs_stray_wen = 1'b1;
            end
            sram_rdata = (k == 1 + RL) ? m : $urandom;
            if (resp_valid) begin
                obs_resp_cycle = k;
                obs_rdata = resp_rdata;
                obs_adel  = resp_adel;
                obs_ades  = resp_ades;
                break;
            end
            if (req_ready) obs_ready_busy = 1'b1;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_rt = '0; sram_rdata = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_checks++; if (sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_sram_en got %b want 0", sram_en); end
        n_checks++; if (sram_wen !== 4'h0) begin n_fail++; $display("FAIL reset_sram_wen got %h want 0", sram_wen); end
        n_checks++; if (sram_addr !== '0) begin n_fail++; $display("FAIL reset_sram_addr got %h want 0", sram_addr); end
        n_checks++; if (sram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_sram_wdata got %h want 0", sram_wdata); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        n_checks++; if ({resp_adel, resp_ades} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {resp_adel, resp_ades}); end
        resetn = 1'b1;
    endtask

    task automatic test_directed_store();
        run_op(SW, 32'h1004, 32'hA1B2C3D4, 32'h0, 1'b0);
        n_checks++; if (obs_en_count !== 1 || obs_en_cycle !== 1) begin n_fail++; $display("FAIL sw_en got count %0d cycle %0d want 1/1", obs_en_count, obs_en_cycle); end
        n_checks++; if (obs_wen !== 4'b1111) begin n_fail++; $display("FAIL sw_wen got %b want 1111", obs_wen); end
        n_checks++; if (obs_addr !== 32'h1004) begin n_fail++; $display("FAIL sw_addr got %h want 00001004", obs_addr); end
        n_checks++; if (obs_wdata !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL sw_wdata got %h want a1b2c3d4", obs_wdata); end
        n_checks++; if (obs_resp_cycle !== 2) begin n_fail++; $display("FAIL sw_resp_cycle got %0d want 2", obs_resp_cycle); end
        run_op(SB, 32'h2003, 32'h000000EE, 32'h0, 1'b0);
        n_checks++; if (obs_wen !== 4'b1000) begin n_fail++; $display("FAIL sb_wen got %b want 1000", obs_wen); end
        n_checks++; if (obs_wdata !== 32'hEEEEEEEE) begin n_fail++; $display("FAIL sb_wdata got %h want eeeeeeee", obs_wdata); end
        n_checks++; if (obs_addr !== 32'h2000) begin n_fail++; $display("FAIL sb_addr got %h want 00002000", obs_addr); end
    endtask

    task automatic test_directed_load();
        run_op(LB, 32'h3001, 32'h0, 32'h12348056, 1'b0);
        n_checks++; if (obs_resp_cycle !== 5) begin n_fail++; $display("FAIL lb_resp_cycle got %0d want 5", obs_resp_cycle); end
        n_checks++; if (obs_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_rdata got %h want ffffff80", obs_rdata); end
        n_checks++; if (obs_wen !== 4'b0000 || obs_en_count !== 1) begin n_fail++; $display("FAIL lb_read got wen %b count %0d want 0000/1", obs_wen, obs_en_count); end
        run_op(LBU, 32'h3001, 32'h0, 32'h12348056, 1'b0);
        n_checks++; if (obs_rdata !== 32'h00000080) begin n_fail++; $display("FAIL lbu_rdata got %h want 00000080", obs_rdata); end
        run_op(LWL, 32'h5001, 32'hAABBCCDD, 32'h11223344, 1'b0);
        n_checks++; if (obs_rdata !== 32'h3344CCDD) begin n_fail++; $display("FAIL lwl_rdata got %h want 3344ccdd", obs_rdata); end
        run_op(LWR, 32'h5002, 32'hAABBCCDD, 32'h11223344, 1'b0);
        n_checks++; if (obs_rdata !== 32'hAABB1122) begin n_fail++; $display("FAIL lwr_rdata got %h want aabb1122", obs_rdata); end
    endtask

    task automatic test_alignment();
`ifdef MEM_ALIGN_CHECK_EN
        run_op(LW, 32'h4002, 32'h5A5A1234, 32'hDEADBEEF, 1'b0);
        n_checks++; if (obs_en_count !== 0) begin n_fail++; $display("FAIL lw_mis_en got %0d want 0", obs_en_count); end
        n_checks++; if ({obs_adel, obs_ades} !== 2'b10) begin n_fail++; $display("FAIL lw_mis_flags got %b want 10", {obs_adel, obs_ades}); end
        n_checks++; if (obs_rdata !== 32'h5A5A1234 || obs_resp_cycle !== 2) begin n_fail++; $display("FAIL lw_mis_resp got %h cycle %0d want 5a5a1234/2", obs_rdata, obs_resp_cycle); end
        run_op(SH, 32'h4001, 32'h0000BEEF, 32'h0, 1'b0);
        n_checks++; if (obs_en_count !== 0 || obs_stray_wen) begin n_fail++; $display("FAIL sh_mis_write got count %0d stray %b want 0/0", obs_en_count, obs_stray_wen); end
        n_checks++; if ({obs_adel, obs_ades} !== 2'b01) begin n_fail++; $display("FAIL sh_mis_flags got %b want 01", {obs_adel, obs_ades}); end
`else
        run_op(LW, 32'h4002, 32'h5A5A1234, 32'hDEADBEEF, 1'b0);
        n_checks++; if (obs_rdata !== 32'hDEADBEEF || obs_adel !== 1'b0) begin n_fail++; $display("FAIL lw_unaligned got %h adel %b want deadbeef/0", obs_rdata, obs_adel); end
        run_op(SH, 32'h4001, 32'h0000BEEF, 32'h0, 1'b0);
        n_checks++; if (obs_wen !== 4'b0011 || obs_ades !== 1'b0) begin n_fail++; $display("FAIL sh_unaligned got wen %b ades %b want 0011/0", obs_wen, obs_ades); end
`endif
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 80; i++) begin
            mem_op_t     op;
            logic [31:0] addr, rt, m;
            exp_t        e;
            op   = all_ops[$urandom_range(0, 11)];
            addr = $urandom;
            rt   = $urandom;
            m    = $urandom;
            e    = model(op, addr, rt, m);
            run_op(op, addr, rt, m, 1'b0);
            n_checks++; if (!obs_ready_offer || obs_ready_busy) begin n_fail++; $display("FAIL rnd%0d_ready offer %b busy %b want 1/0", i, obs_ready_offer, obs_ready_busy); end
            n_checks++; if (obs_en_count !== e.en_count || obs_stray_wen) begin n_fail++; $display("FAIL rnd%0d_en op %0d got %0d stray %b want %0d", i, op, obs_en_count, obs_stray_wen, e.en_count); end
            n_checks++; if (obs_resp_cycle !== e.resp_cycle) begin n_fail++; $display("FAIL rnd%0d_latency op %0d got %0d want %0d", i, op, obs_resp_cycle, e.resp_cycle); end
            n_checks++; if (obs_rdata !== e.rdata) begin n_fail++; $display("FAIL rnd%0d_rdata op %0d addr %h got %h want %h", i, op, addr, obs_rdata, e.rdata); end
            n_checks++; if ({obs_adel, obs_ades} !== {e.adel, e.ades}) begin n_fail++; $display("FAIL rnd%0d_flags op %0d got %b want %b", i, op, {obs_adel, obs_ades}, {e.adel, e.ades}); end
            if (e.en_count == 1) begin
                n_checks++; if (obs_en_cycle !== 1 || obs_addr !== (addr & 32'hFFFFFFFC)) begin n_fail++; $display("FAIL rnd%0d_addr got %h cycle %0d want %h/1", i, obs_addr, obs_en_cycle, addr & 32'hFFFFFFFC); end
                n_checks++; if (obs_wen !== e.wen) begin n_fail++; $display("FAIL rnd%0d_wen op %0d addr %h got %b want %b", i, op, addr, obs_wen, e.wen); end
                if (e.wen != 4'b0000) begin
                    n_checks++; if (obs_wdata !== e.wdata) begin n_fail++; $display("FAIL rnd%0d_wdata op %0d addr %h got %h want %h", i, op, addr, obs_wdata, e.wdata); end
                end
            end
        end
    endtask

    task automatic test_undefined_ops();
        for (int v = 0; v < 16; v++) begin
            bit          defined;
            logic [31:0] rt;
            defined = 1'b0;
            foreach (all_ops[j]) if (4'(v) == all_ops[j]) defined = 1'b1;
            if (!defined) begin
                rt = $urandom;
                run_op(4'(v), $urandom, rt, $urandom, 1'b0);
                n_checks++; if (obs_en_count !== 0 || obs_stray_wen) begin n_fail++; $display("FAIL undef%0d_en got %0d want 0", v, obs_en_count); end
                n_checks++; if (obs_resp_cycle !== 2 || obs_rdata !== rt) begin n_fail++; $display("FAIL undef%0d_resp got %h cycle %0d want %h/2", v, obs_rdata, obs_resp_cycle, rt); end
                n_checks++; if ({obs_adel, obs_ades} !== 2'b00) begin n_fail++; $display("FAIL undef%0d_flags got %b want 00", v, {obs_adel, obs_ades}); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        run_op(LH, 32'h7002, 32'h0, 32'h8001_1234, 1'b1);
        n_checks++; if (obs_resp_cycle !== 2 + RL || obs_rdata !== 32'hFFFF8001) begin n_fail++; $display("FAIL busy_lh got %h cycle %0d want ffff8001/%0d", obs_rdata, obs_resp_cycle, 2 + RL); end
        n_checks++; if (obs_en_count !== 1 || obs_ready_busy) begin n_fail++; $display("FAIL busy_accept got count %0d ready %b want 1/0", obs_en_count, obs_ready_busy); end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (sram_en || resp_valid || !req_ready) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL busy_idle_after got activity 1 want 0"); end
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h6000; req_rt = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || sram_en !== 1'b0) begin n_fail++; $display("FAIL abort_wait got ready %b resp %b en %b want 1/0/0", req_ready, resp_valid, sram_en); end
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid || sram_en || !req_ready) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL abort_wait_quiet got activity 1 want 0"); end
        @(negedge clk);
        req_valid = 1'b1; req_op = SW; req_addr = 32'h6004; req_rt = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        resetn = 1'b0;
        #1;
        n_checks++; if (sram_en !== 1'b0 || sram_wen !== 4'h0) begin n_fail++; $display("FAIL abort_issue got en %b wen %b want 0/0000", sram_en, sram_wen); end
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || sram_en) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL abort_issue_quiet got activity 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_directed_store();
        test_directed_load();
        test_alignment();
        test_random_ops();
        test_undefined_ops();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised multi-cycle load/store sequencer for the multi-cycle MIPS core. It replaces the core's fixed ST/LD/RDW states and inline byte-lane logic with a handshaked unit. The core hands it one memory operation. The unit drives the data SRAM port, waits a configurable read latency, and returns merged/extended load data and address-error flags. It sits between the core's EX stage and the data SRAM.

## Interface
Parameters:
- ADDR_W, 32, address width of req_addr and sram_addr (≥3).
- READ_LAT, 1, cycles from the cycle sram_en is high to the cycle sram_rdata is valid; legal range 1..8.

Ports:
- clk  in  1  core clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  operation offered.
- req_ready  out  1  unit idle; accepts on req_valid & req_ready.
- req_op  in  4  mem_op_t encoding (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR).
- req_addr  in  ADDR_W  effective byte address (rs + offset).
- req_rt  in  32  rt value: store data, and old value merged into LWL/LWR.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result (stores: req_rt echoed).
- resp_adel  out  1  load address error, valid with resp_valid.
- resp_ades  out  1  store address error, valid with resp_valid.
- sram_en  out  1  SRAM access enable.
- sram_wen  out  4  byte write strobes, 0 for reads.
- sram_addr  out  ADDR_W  word address {req_addr[ADDR_W-1:2], 2'b00}.
- sram_wdata  out  32  lane-aligned store data.
- sram_rdata  in  32  SRAM read data.

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, DONE. req_ready = (state == IDLE).
- IDLE: on accept, latch op, addr, rt. Go to ISSUE.
- ISSUE: sram_en = 1 for exactly one cycle. sram_wen = store strobes (0 for loads).
  - Stores go to DONE.
  - Loads go to WAIT with cnt = READ_LAT-1.
- WAIT: lasts READ_LAT cycles. On the last one (cnt == 0), register the merged load result from sram_rdata and go to DONE.
- DONE: resp_valid = 1 for one cycle, then IDLE. A new request is accepted only in IDLE, so there is no accept in the same cycle as DONE.
- Byte offset ea = addr[1:0], little-endian.
- Store data and strobes:
  - SB: wen = 1<<ea, wdata = {4{rt[7:0]}}.
  - SH: wen = ea[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}.
  - SW: wen = 1111, wdata = rt.
  - SWL, ea 0..3: wen = 0001 / 0011 / 0111 / 1111, wdata = rt>>24 / >>16 / >>8 / rt.
  - SWR, ea 0..3: wen = 1111 / 1110 / 1100 / 1000, wdata = rt / <<8 / <<16 / <<24.
- Load results (m = sram_rdata):
  - LB/LBU: byte ea, sign- or zero-extended.
  - LH/LHU: half ea[1], sign- or zero-extended.
  - LW: m.
  - LWL, ea 0..3: {m[7:0],rt[23:0]}, {m[15:0],rt[15:0]}, {m[23:0],rt[7:0]}, m.
  - LWR, ea 0..3: m, {rt[31:24],m[31:8]}, {rt[31:16],m[31:16]}, {rt[31:8],m[31:24]}.
- Undefined req_op: ISSUE with sram_en = 0, then DONE with resp_rdata = rt and no error flag.
- req_valid while busy is ignored. req_* inputs are don't-care after accept.

## Timing
- Accept at edge 0. ISSUE in cycle 1. Store resp_valid in cycle 2.
- Load: WAIT in cycles 2..1+READ_LAT; resp_valid in cycle 2+READ_LAT (READ_LAT=1: cycle 3).
- All outputs are registered or decoded from state; there is no combinational path from req_* to sram_*.
- Reset values: state IDLE, req_ready 1, sram_en 0, sram_wen 0, sram_addr 0, sram_wdata 0, resp_valid 0, resp_rdata 0, resp_adel 0, resp_ades 0, cnt 0.
- Reset asserted mid-operation aborts immediately. No response is produced and any pending write is dropped.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - A misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) goes ISSUE→DONE with sram_en = 0.
  - resp_adel (loads) or resp_ades (stores) = 1, resp_rdata = rt.
- MEM_ALIGN_CHECK_EN undefined:
  - resp_adel and resp_ades are tied 0.
  - Misaligned accesses proceed: halfword ops ignore addr[0]; word ops ignore addr[1:0].

## Structure
- Package mem_pkg holds: mem_op_t enum (4-bit), FSM state enum, helpers is_load/is_store/needs_align.
- One sub-module, mem_lane_align: purely combinational; computes strobes, store wdata, and the load merge/extend from op, ea, rt, m.
- The top holds the FSM, latch registers, and latency counter.

## Test plan
- SW addr 0x1004, rt 0xA1B2C3D4 → cycle 1: sram_en=1, wen=1111, sram_addr=0x1004, wdata=0xA1B2C3D4; cycle 2: resp_valid.
- SB addr 0x2003, rt 0x000000EE → wen=1000, wdata=0xEEEEEEEE.
- LB addr 0x3001, m=0x12348056, READ_LAT=3 → resp_valid at cycle 5, rdata=0xFFFFFF80. The same with LBU gives 0x00000080.
- LWL addr ea=1, m=0x11223344, rt=0xAABBCCDD → 0x3344CCDD. LWR ea=2 → 0xAABB1122.
- With MEM_ALIGN_CHECK_EN: LW addr 0x4002 → sram_en never high, resp_adel=1, rdata=rt. SH addr 0x4001 → resp_ades=1, no write.
- Reset pulsed during WAIT → req_ready=1 after release, no resp_valid. A request issued while busy is not accepted.
